// File: rtl/cas_pkg.sv
// Shared constants and helpers for the FSK cassette-tone serializer.
//   SLOTS_ONE / SLOTS_ZERO : tick-slots per '1' / '0' symbol
//   TICK_HZ_NOM            : nominal slot tick rate
//   STEP_DEFAULT           : NCO increment giving ~4800 Hz from the system clock
//   tx_state_e             : serializer state (idle / shifting a word)
package cas_pkg;

  localparam int          SLOTS_ONE    = 2;
  localparam int          SLOTS_ZERO   = 4;
  localparam int          TICK_HZ_NOM  = 4800;
  localparam int unsigned STEP_DEFAULT = 90687;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_e;

  // Index of the final slot of the symbol for a given bit value.
  function automatic logic [1:0] last_slot(input logic bit_val);
    return bit_val ? 2'(SLOTS_ONE - 1) : 2'(SLOTS_ZERO - 1);
  endfunction

  // Number of leading slots that are driven high (first half of the cycle).
  function automatic logic [1:0] high_slots(input logic bit_val);
    return bit_val ? 2'(SLOTS_ONE / 2) : 2'(SLOTS_ZERO / 2);
  endfunction

endpackage

// File: rtl/cas_tick_nco.sv
// Fractional NCO slot-tick generator.
//   clk, reset_n : system clock, async active-low reset
//   clr          : synchronous accumulator clear (wins over run)
//   run          : advance the accumulator this cycle
//   tick         : carry out of acc+STEP while running (combinational)
module cas_tick_nco
  import cas_pkg::*;
#(
  parameter int          ACC_W = 24,
  parameter int unsigned STEP  = STEP_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam logic [ACC_W:0] STEP_EXT = (ACC_W + 1)'(STEP);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W:0]   w_sum;

  // One bit wider than the accumulator: the MSB is the carry/tick, the rest wraps.
  assign w_sum = {1'b0, r_acc} + STEP_EXT;
  assign tick  = run & w_sum[ACC_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (run) begin
      r_acc <= w_sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/cas_fsk_stream_tx.sv
// Streaming FSK cassette-tone serializer.
// A '1' bit is one tone cycle over 2 tick-slots, a '0' bit one cycle over 4 slots,
// high half first. Words enter through valid/ready with a single holding register
// so that back-to-back words play without a gap.
//   clk, reset_n : system clock, async active-low reset
//   enable       : play gate; low aborts the stream synchronously
//   in_valid     : in_data is valid
//   in_data      : word to transmit (DATA_W bits)
//   in_ready     : holding register empty (and enabled)
//   busy         : a word is being shifted out
//   word_done    : 1-clk pulse after every word
//   done         : 1-clk pulse when the stream drains
//   dout         : tone output
module cas_fsk_stream_tx
  import cas_pkg::*;
#(
  parameter int          ACC_W     = 24,
  parameter int unsigned STEP      = STEP_DEFAULT,
  parameter int          DATA_W    = 8,
  parameter int          MSB_FIRST = 0,
  parameter bit          IDLE_LVL  = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              word_done,
  output logic              done,
  output logic              dout
);

  localparam int              BC_W     = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

  tx_state_e         r_state;
  logic              r_hold_vld;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_shift;
  logic [1:0]        r_sc;
  logic [BC_W-1:0]   r_bitcnt;
  logic              r_word_done;
  logic              r_done;

  logic              w_busy;
  logic              w_tick;
  logic              w_cur_bit;
  logic              w_bit_end;
  logic              w_word_end;
  logic              w_accept;
  logic              w_shift_free;
  logic              w_load;
  logic              w_nco_clr;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_shift_next;

  assign w_busy    = (r_state == ST_SHIFT);
  assign w_cur_bit = (MSB_FIRST != 0) ? r_shift[DATA_W-1] : r_shift[0];

  cas_tick_nco #(
    .ACC_W (ACC_W),
    .STEP  (STEP)
  ) u_nco (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_nco_clr),
    .run     (w_busy),
    .tick    (w_tick)
  );

  assign w_bit_end  = w_busy & w_tick & (r_sc == last_slot(w_cur_bit));
  assign w_word_end = w_bit_end & (r_bitcnt == LAST_BIT);

  assign in_ready     = enable & ~r_hold_vld;
  assign w_accept     = in_valid & in_ready;
  // The shifter can take a word when idle or on the edge its last slot ends;
  // a word accepted into an empty hold at that moment bypasses the hold.
  assign w_shift_free = ~w_busy | w_word_end;
  assign w_load       = enable & w_shift_free & (r_hold_vld | w_accept);
  assign w_load_data  = r_hold_vld ? r_hold : in_data;
  // Clearing on load keeps every word phase-aligned to its own start.
  assign w_nco_clr    = ~enable | w_load;
  assign w_shift_next = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_hold_vld  <= 1'b0;
      r_sc        <= '0;
      r_bitcnt    <= '0;
      r_word_done <= 1'b0;
      r_done      <= 1'b0;
    end else if (!enable) begin
      r_state     <= ST_IDLE;
      r_hold_vld  <= 1'b0;
      r_sc        <= '0;
      r_bitcnt    <= '0;
      r_word_done <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_word_done <= w_word_end;
      r_done      <= w_word_end & ~w_load;
      // With the hold empty, a load can only come from a direct accept.
      r_hold_vld  <= r_hold_vld ? ~w_load : (w_accept & ~w_load);
      if (w_load) begin
        r_state  <= ST_SHIFT;
        r_sc     <= '0;
        r_bitcnt <= '0;
      end else if (w_word_end) begin
        r_state  <= ST_IDLE;
        r_sc     <= '0;
        r_bitcnt <= '0;
      end else if (w_bit_end) begin
        r_sc     <= '0;
        r_bitcnt <= r_bitcnt + BC_W'(1);
      end else if (w_busy && w_tick) begin
        r_sc     <= r_sc + 2'd1;
      end
    end
  end

  // Word storage carries no reset: its contents only matter once marked valid.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hold <= in_data;
    end
    if (w_load) begin
      r_shift <= w_load_data;
    end else if (w_bit_end) begin
      r_shift <= w_shift_next;
    end
  end

  assign busy      = w_busy;
  assign word_done = r_word_done;
  assign done      = r_done;
  assign dout      = w_busy ? (r_sc < high_slots(w_cur_bit)) : IDLE_LVL;

endmodule

// File: tb/tb_cas_fsk_stream_tx.sv
module tb_cas_fsk_stream_tx;

  localparam int TPS = 2;  // clocks per slot with STEP = 2^23, ACC_W = 24

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       in_valid;
  logic [7:0] in_data;
  logic       sel;  // 0: monitor/drive dut (8-bit LSB first); 1: dut2 (4-bit MSB first)

  logic d1_ready, d1_busy, d1_wd, d1_dn, d1_dout;
  logic d2_ready, d2_busy, d2_wd, d2_dn, d2_dout;
  logic d1_valid, d2_valid;
  logic m_ready, m_busy, m_wd, m_dn, m_dout;

  assign d1_valid = in_valid & ~sel;
  assign d2_valid = in_valid & sel;
  assign m_ready  = sel ? d2_ready : d1_ready;
  assign m_busy   = sel ? d2_busy  : d1_busy;
  assign m_wd     = sel ? d2_wd    : d1_wd;
  assign m_dn     = sel ? d2_dn    : d1_dn;
  assign m_dout   = sel ? d2_dout  : d1_dout;

  always #5 clk = ~clk;

  cas_fsk_stream_tx #(
    .ACC_W(24), .STEP(32'h0080_0000), .DATA_W(8), .MSB_FIRST(0), .IDLE_LVL(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(d1_valid),
    .in_data(in_data), .in_ready(d1_ready), .busy(d1_busy),
    .word_done(d1_wd), .done(d1_dn), .dout(d1_dout)
  );

  cas_fsk_stream_tx #(
    .ACC_W(24), .STEP(32'h0080_0000), .DATA_W(4), .MSB_FIRST(1), .IDLE_LVL(1'b1)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(d2_valid),
    .in_data(in_data[3:0]), .in_ready(d2_ready), .busy(d2_busy),
    .word_done(d2_wd), .done(d2_dn), .dout(d2_dout)
  );

  typedef struct {
    logic [7:0] data;
    int         exp_clk;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int wd_cnt, dn_cnt;
  logic       cap_q[$];
  logic       exp_q[$];
  logic [7:0] feed_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference tone: each bit is one cycle, high half first, over 2 or 4 slots.
  function automatic void model_word(input logic [15:0] w, input int nb, input bit msb);
    logic b;
    int   ns;
    for (int i = 0; i < nb; i++) begin
      b  = msb ? w[nb-1-i] : w[i];
      ns = b ? 2 : 4;
      for (int s = 0; s < ns; s++)
        for (int t = 0; t < TPS; t++) exp_q.push_back(s < ns / 2);
    end
  endfunction

  task automatic clear_cap();
    cap_q.delete();
    exp_q.delete();
    wd_cnt = 0;
    dn_cnt = 0;
  endtask

  task automatic step_cap();
    @(posedge clk);
    #1;
    if (m_busy) cap_q.push_back(m_dout);
    if (m_wd) wd_cnt++;
    if (m_dn) dn_cnt++;
  endtask

  task automatic compare_wave(input string name);
    int mism;
    int n;
    mism = 0;
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (cap_q[i] !== exp_q[i]) mism++;
    check({name, "_len"}, cap_q.size(), exp_q.size());
    check({name, "_mismatch"}, mism, 0);
  endtask

  // Feed feed_q whenever in_ready is high; stop at the first non-busy cycle after playing.
  task automatic run_stream(input string name, input int maxc, output int bcyc);
    bit started;
    bit ended;
    bit took;
    started = m_busy;
    ended   = 1'b0;
    bcyc    = 0;
    for (int c = 0; c < maxc; c++) begin
      took = 1'b0;
      if (feed_q.size() != 0 && m_ready) begin
        in_valid = 1'b1;
        in_data  = feed_q[0];
        took     = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step_cap();
      if (took) void'(feed_q.pop_front());
      if (m_busy) begin
        started = 1'b1;
        bcyc++;
      end else if (started) begin
        ended = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    check({name, "_ended"}, ended, 1);
    check({name, "_fed_all"}, feed_q.size(), 0);
    repeat (3) step_cap();
    check({name, "_idle_dout"}, m_dout, 1);
  endtask

  vec_t tbl[6];
  int   bcyc;
  int   n;
  logic [7:0] w;

  initial begin
    tbl[0] = '{8'hA5, 48};
    tbl[1] = '{8'hFF, 32};
    tbl[2] = '{8'h00, 64};
    tbl[3] = '{8'h01, 60};
    tbl[4] = '{8'h80, 60};
    tbl[5] = '{8'h3C, 48};

    reset_n = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = '0; sel = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_ready", m_ready, 1);
    check("rst_busy", m_busy, 0);
    check("rst_dout", m_dout, 1);
    check("rst_word_done", m_wd, 0);
    check("rst_done", m_dn, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    clear_cap();
    repeat (2) step_cap();

    // Single words from the table.
    for (int i = 0; i < 6; i++) begin
      clear_cap();
      feed_q.push_back(tbl[i].data);
      model_word({8'h00, tbl[i].data}, 8, 1'b0);
      run_stream($sformatf("word%0d", i), 200, bcyc);
      check($sformatf("word%0d_clks", i), bcyc, tbl[i].exp_clk);
      compare_wave($sformatf("word%0d_wave", i));
      check($sformatf("word%0d_word_done", i), wd_cnt, 1);
      check($sformatf("word%0d_done", i), dn_cnt, 1);
      if (i == 0) begin
        // 0xA5 opens with slots H,L (bit 1) then H,H,L,L (bit 0).
        check("a5_slot0", cap_q[0], 1);
        check("a5_slot1", cap_q[2], 0);
        check("a5_slot2", cap_q[4], 1);
        check("a5_slot3", cap_q[6], 1);
        check("a5_slot4", cap_q[8], 0);
        check("a5_slot5", cap_q[10], 0);
      end
    end

    // Back-to-back 0xFF then 0x00: 16 + 32 slots, gap-free, single done.
    clear_cap();
    feed_q.push_back(8'hFF);
    feed_q.push_back(8'h00);
    model_word(16'hFF, 8, 1'b0);
    model_word(16'h00, 8, 1'b0);
    run_stream("b2b", 300, bcyc);
    check("b2b_clks", bcyc, 96);
    compare_wave("b2b_wave");
    check("b2b_word_done", wd_cnt, 2);
    check("b2b_done", dn_cnt, 1);

    // Randomized gap-free streams against the reference tone.
    for (int it = 0; it < 6; it++) begin
      clear_cap();
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        w = 8'($urandom_range(0, 255));
        feed_q.push_back(w);
        model_word({8'h00, w}, 8, 1'b0);
      end
      run_stream($sformatf("rnd%0d", it), 400, bcyc);
      compare_wave($sformatf("rnd%0d_wave", it));
      check($sformatf("rnd%0d_word_done", it), wd_cnt, n);
      check($sformatf("rnd%0d_done", it), dn_cnt, 1);
    end

    // Reset mid-word: immediate idle outputs, no pulses.
    clear_cap();
    in_valid = 1'b1; in_data = 8'h00;
    step_cap();
    in_valid = 1'b0;
    repeat (7) step_cap();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_dout", m_dout, 1);
    check("midrst_busy", m_busy, 0);
    check("midrst_ready", m_ready, 1);
    check("midrst_done", m_dn, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) step_cap();
    check("midrst_pulses", wd_cnt + dn_cnt, 0);

    // Abort with enable low in slot 5 of 0x00, then re-enable and play 0x01.
    clear_cap();
    in_valid = 1'b1; in_data = 8'h00;
    step_cap();
    in_valid = 1'b0;
    repeat (11) step_cap();
    enable = 1'b0;
    #1 check("abort_ready_low", m_ready, 0);
    step_cap();
    check("abort_dout", m_dout, 1);
    check("abort_busy", m_busy, 0);
    repeat (4) step_cap();
    check("abort_pulses", wd_cnt + dn_cnt, 0);
    enable = 1'b1;
    #1 check("abort_ready_back", m_ready, 1);
    clear_cap();
    feed_q.push_back(8'h01);
    model_word(16'h01, 8, 1'b0);
    run_stream("reen", 200, bcyc);
    compare_wave("reen_wave");
    check("reen_done", dn_cnt, 1);

    // Same-cycle: next word offered exactly on the word-end edge with hold empty.
    clear_cap();
    model_word(16'hFF, 8, 1'b0);
    model_word(16'h5A, 8, 1'b0);
    in_valid = 1'b1; in_data = 8'hFF;
    step_cap();
    in_valid = 1'b0;
    repeat (31) step_cap();
    in_valid = 1'b1; in_data = 8'h5A;
    step_cap();
    in_valid = 1'b0;
    check("same_busy", m_busy, 1);
    check("same_ready", m_ready, 1);
    check("same_cap", cap_q.size(), 33);
    check("same_no_done", dn_cnt, 0);
    run_stream("same", 200, bcyc);
    compare_wave("same_wave");
    check("same_word_done", wd_cnt, 2);
    check("same_done", dn_cnt, 1);

    // MSB-first 4-bit instance; extra valid while hold is full must be ignored.
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 enable = 1'b1;
    sel = 1'b1;
    clear_cap();
    model_word(16'h8, 4, 1'b1);
    model_word(16'h3, 4, 1'b1);
    in_valid = 1'b1; in_data = 8'h08;
    step_cap();
    in_data = 8'h03;
    step_cap();
    check("msb_hold_full", m_ready, 0);
    in_data = 8'h0C;
    repeat (5) step_cap();
    in_valid = 1'b0;
    run_stream("msb", 200, bcyc);
    check("msb_first_word_len", (exp_q.size() >= 28) ? 28 : 0, 28);
    compare_wave("msb_wave");
    check("msb_word_done", wd_cnt, 2);
    check("msb_done", dn_cnt, 1);
    sel = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
